// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) between the refill arbiter and the AXI bridge.
// master = arbiter side, slave = bridge side.
interface cache_axi_rd_arbiter_if #(
  parameter int ID_W = 4
);
  logic            arvalid;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arready;
  logic            rvalid;
  logic [31:0]     rdata;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            rready;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast, rid
  );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Round-robin icache/dcache line-refill arbiter onto one AXI read port; request->arvalid 1 cycle.
// No buffering: granted cache's data_ready drives rready combinationally, R beats go to the grantee only.
module cache_axi_rd_arbiter #(
  parameter int LINE_BEATS = 16,
  parameter int ID_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_r_req,
  input  logic [31:0]            ic_r_addr,
  input  logic                   ic_r_data_ready,
  output logic                   ic_r_rdy,
  output logic                   ic_ret_valid,
  output logic                   ic_ret_last,
  input  logic                   dc_r_req,
  input  logic [31:0]            dc_r_addr,
  input  logic                   dc_r_data_ready,
  output logic                   dc_r_rdy,
  output logic                   dc_ret_valid,
  output logic                   dc_ret_last,
  output logic [31:0]            ret_data,
  cache_axi_rd_arbiter_if.master axi,
  output logic                   busy,
  output logic                   proto_err
);
  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic             grant;       // 0 = icache, 1 = dcache
  logic             last_grant;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [ID_W-1:0]  grant_id;
  logic             any_req, pick_dc;
  logic             ar_hs, r_hs, rready_i, beat_err;

  assign any_req  = ic_r_req | dc_r_req;
  // On a tie the requester not served last wins.
  assign pick_dc  = dc_r_req & (~ic_r_req | ~last_grant);
  assign grant_id = grant ? ID_W'(1) : ID_W'(0);
  assign beat_err = (axi.rid != grant_id) | (axi.rlast != (beat_cnt == LAST_BEAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ar_hs        = 1'b0;
    r_hs         = 1'b0;
    rready_i     = 1'b0;
    axi.arvalid  = 1'b0;
    ic_r_rdy     = 1'b0;
    dc_r_rdy     = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = ADDR;
      ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          ar_hs     = 1'b1;
          ic_r_rdy  = ~grant;
          dc_r_rdy  = grant;
          state_nxt = DATA;
        end
      end
      DATA: begin
        rready_i = grant ? dc_r_data_ready : ic_r_data_ready;
        if (axi.rvalid && rready_i) begin
          r_hs         = 1'b1;
          ic_ret_valid = ~grant;
          dc_ret_valid = grant;
          ic_ret_last  = ~grant & axi.rlast;
          dc_ret_last  = grant & axi.rlast;
          if (axi.rlast) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        grant    <= pick_dc;
        addr_q   <= pick_dc ? dc_r_addr : ic_r_addr;
        beat_cnt <= '0;
      end
      if (ar_hs) last_grant <= grant;
      if (r_hs) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (beat_err) proto_err <= 1'b1;
      end
    end
  end

  assign axi.rready  = rready_i;
  assign axi.araddr  = addr_q;
  assign axi.arid    = grant_id;
  assign axi.arlen   = 8'(LINE_BEATS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign ret_data    = axi.rdata;
  assign busy        = (state != IDLE);
endmodule
